// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register file geometry
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: round-robin first-set search starting at ptr and wrapping
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] k;
    always_comb begin
        idx = '0;
        k   = '0;
        // walk from farthest to nearest so the entry closest to ptr wins
        for (int i = N - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % N);
            if (req[k]) idx = k;
        end
        any   = |req;
        grant = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register file write port
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = REG_ADDR_W,
    parameter int DATA_W      = REG_DATA_W,
    parameter bit ZERO_REG_RO = 1'b1,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      freeze,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [IW-1:0]             wr_src,
    output logic                      zero_drop
);
    logic [IW-1:0]      ptr, idx;
    logic [NUM_REQ-1:0] grant;
    logic               any, accept, is_zero;
    logic [ADDR_W-1:0]  win_addr;

    rr_priority_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    // reset gates ready so nothing handshakes while the outputs are held clear
    assign accept    = any && !freeze && rst_n;
    assign req_ready = accept ? grant : '0;
    assign win_addr  = req_addr[idx*ADDR_W +: ADDR_W];
    assign is_zero   = ZERO_REG_RO && win_addr == ADDR_W'(ZERO_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_src    <= '0;
            zero_drop <= 1'b0;
        end else begin
            wr_en     <= accept && !is_zero;
            zero_drop <= accept && is_zero;
            if (accept) begin
                wr_addr <= win_addr;
                wr_data <= req_data[idx*DATA_W +: DATA_W];
                wr_src  <= idx;
                ptr     <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32-entry register file between NUM_REQ requesters using a round-robin policy.
- Accepts requests over a valid/ready handshake and registers the winning address/data for one cycle.
- Its wr_en/wr_addr/wr_data outputs drive the register file write-enable path (the 5-bit address goes to the 32-way write decoder, gated by wr_en).
- Sits between the execute/writeback sources (ALU, load unit, etc.) and the register file.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 5, register address width (32 entries).
- DATA_W, 32, register data width.
- ZERO_REG_RO, 1, when 1 writes to address 0 are accepted but never reach the register file.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; same packing as req_addr.
- req_ready  output  NUM_REQ  one-hot grant; the handshake completes on req_valid[i] && req_ready[i].
- freeze  input  1  when high, no grants are issued; used during scan/readback.
- wr_en  output  1  register file write enable, one cycle per accepted write.
- wr_addr  output  ADDR_W  register file write address.
- wr_data  output  DATA_W  register file write data.
- wr_src  output  $clog2(NUM_REQ)  index of the requester that produced the current write.
- zero_drop  output  1  one-cycle pulse when an accepted write to address 0 was suppressed.

Behaviour:
- Reset (async assert, sync release): wr_en=0, wr_addr=0, wr_data=0, wr_src=0, zero_drop=0, priority pointer ptr=0.
- Grant is combinational in the same cycle. req_ready is asserted for the first i with req_valid[i]=1, searching ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1.
  - At most one bit of req_ready is set.
  - req_ready is 0 everywhere when freeze=1 or no request is valid.
- req_ready never depends on req_addr or req_data.
- Requester rule: once req_valid[i] rises, it and the address/data hold until the handshake completes. A bench assertion flags violations; RTL behaviour under violation is undefined.
- Accept in cycle T → at edge T+1 the block registers wr_addr, wr_data and wr_src from the winner.
  - wr_en=1 during cycle T+1 (latency 1).
  - A new accept in T+1 keeps wr_en high in T+2, giving back-to-back writes at full throughput.
- With no accept in cycle T, wr_en=0 in T+1. wr_addr, wr_data and wr_src hold their last values.
- ZERO_REG_RO=1 and the winner's address is 0: the handshake completes normally, wr_en stays 0 next cycle, and zero_drop=1 next cycle. wr_addr/wr_data still update.
- ZERO_REG_RO=0: address 0 is treated like any other address.
- Pointer update on accept by requester g: ptr <= (g+1) mod NUM_REQ. No accept: ptr holds. freeze holds ptr.
- A single active requester is granted every cycle; no idle bubble.
- Same-address requests from two requesters are serialized in round-robin order; the later write lands last. No merging, no forwarding.
- freeze asserted mid-stream: a write already registered still completes (wr_en=1 that cycle). No new grant occurs while freeze=1.
- Reset asserted mid-operation: outputs clear immediately (asynchronously) and in-flight writes are lost. Requesters are not ready during reset.

Decomposition:
- Shared package regfile_pkg: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, ZERO_REG=0.
- One sub-module, rr_priority_pick.
  - Inputs: req vector, ptr. Outputs: one-hot grant, encoded index, any.
  - Purely combinational; reused by the planned read-port arbiter.
- The pointer and output registers stay in regfile_write_arbiter.

Test Plan:
- Reset: rst_n=0 with all req_valid=1 → req_ready=0, wr_en=0, wr_addr=0, wr_data=0. Release → req0 is granted first (ptr=0).
- All four valid continuously (addresses 1,2,3,4; data 0xA..0xD) → grants 0,1,2,3,0,…; wr_en=1 every cycle from T+1; wr_addr sequence 1,2,3,4 with matching data.
- Only req2 valid for 5 cycles (addr 7, data 0x55) → req_ready[2]=1 every cycle; five consecutive wr_en pulses to addr 7.
- ZERO_REG_RO=1, req1 writes addr 0 with data 0xFFFF_FFFF → handshake completes; next cycle wr_en=0, zero_drop=1. Rerun with ZERO_REG_RO=0 → wr_en=1 at addr 0.
- freeze=1 while req0 and req3 are valid → req_ready=0 and ptr held. Deassert → the grant goes to the requester nearest ptr.
- Reset pulse asserted asynchronously between clock edges mid-stream → wr_en drops immediately. After release, the arbiter restarts from ptr=0 and no stale write appears.
